ahb_mstr_sif: RTL
=================

# ahb_mstr_sif

AHB-lite initiator interface: converts a simple client request/response handshake into single AHB-lite transfers (SINGLE bursts, NONSEQ only) and returns read data or error status to the client. It is the initiator-side counterpart of the crypto-block slave interfaces. It lets block-level DMA/sequencer logic, and the block-level benches, drive any AHB-lite slave such as the SHA512 register space. Address and data phases are pipelined, so back-to-back requests issue on consecutive cycles.

## Interface
- AHB_ADDR_WIDTH, 32, haddr/request address width
- AHB_DATA_WIDTH, 64, bus data width; legal values 32 or 64
- CLIENT_DATA_WIDTH, 32, request/response data width; fixed 32
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  client request valid
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AHB_ADDR_WIDTH  byte address, dword aligned (addr[1:0] ignored, driven 0)
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse; client cannot stall it
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  slave returned ERROR; valid with rsp_valid
- haddr_o  out  AHB_ADDR_WIDTH  address phase address
- htrans_o  out  2  IDLE 2'b00 / NONSEQ 2'b10
- hwrite_o  out  1  address phase direction
- hsize_o  out  3  constant 3'b010 (word)
- hburst_o  out  3  constant 3'b000 (SINGLE)
- hwdata_o  out  AHB_DATA_WIDTH  data phase write data
- hready_i  in  1  bus ready
- hresp_i  in  1  bus error response
- hrdata_i  in  AHB_DATA_WIDTH  read data

## Operation
- Two register stages:
  - A (address phase): a_vld, a_addr, a_write, a_wdata.
  - D (data phase): d_vld, d_addr2 (= addr[2]), d_write, d_wdata.
- While a_vld, the block drives htrans_o = NONSEQ with haddr_o/hwrite_o from A. Otherwise it drives IDLE, and haddr_o/hwrite_o hold their last values.
- addr_accept = a_vld & hready_i & !cancel.
  - At that edge, A moves to D (d_vld = 1).
  - If no new request is loaded at the same edge, a_vld clears.
- req_ready = !a_vld | addr_accept. This is a combinational path from hready_i, and it gives one transfer per cycle at zero wait states.
- Write lanes: with a 64-bit bus, hwdata_o = {d_wdata, d_wdata}; with a 32-bit bus, hwdata_o = d_wdata. hwdata_o is driven throughout the data phase.
- Read lanes: rdata = d_addr2 ? hrdata_i[63:32] : hrdata_i[31:0] on a 64-bit bus; hrdata_i[31:0] on a 32-bit bus.
- Data-phase completion: d_vld & hready_i at an edge.
  - The following cycle: rsp_valid = 1 and rsp_err = hresp_i as sampled; rsp_rdata = selected lane for a read without error, else 0.
  - d_vld clears unless addr_accept occurs at the same edge.
- Error handling: AHB error response is two cycles.
  - cancel = d_vld & hresp_i & !hready_i (first error cycle).
  - The cycle after cancel, htrans_o is forced to IDLE, even if a_vld is set.
  - The pending A transfer is not dropped. It is re-issued as NONSEQ after the error completes.
  - Responses are therefore always returned in request order.
- Slave backpressure: hready_i = 0 in the data phase holds D, and holds A and haddr_o stable.

## Timing
- All outputs reset to 0; htrans_o = IDLE; req_ready = 1.
- Read latency, zero wait states:
  - Request accepted at edge 0.
  - NONSEQ driven in cycle 1.
  - Data phase in cycle 2.
  - rsp_valid in cycle 3.
- Each slave wait state adds one cycle.
- Throughput: 1 transfer/cycle sustained with hready_i = 1.
- Simultaneous events at one edge are all legal: request load, A→D transfer, and D completion.
- Reset asserted mid-transfer: A/D cleared immediately, outstanding transfers are discarded without rsp_valid, and htrans_o = IDLE asynchronously.

## Structure
- Shared package ahb_lite_pkg holds:
  - HTRANS_IDLE / HTRANS_NONSEQ
  - HSIZE_WORD, HBURST_SINGLE
  - typedef ahb_mstr_req_t {write, addr, wdata}
- Single module; no sub-module is needed. The read lane mux stays inline.

## Test plan
- Write 0x1234_5678 to 0x0000_0044 with no waits:
  - NONSEQ with haddr 0x44 in cycle 1.
  - hwdata_o = 0x12345678_12345678 in cycle 2.
  - rsp_valid in cycle 3 with rsp_err = 0.
- Read 0x0000_0004 with hrdata_i = 0xAAAA_BBBB_CCCC_DDDD: rsp_rdata = 0xAAAA_BBBB.
- Read 0x0000_0000 with the same hrdata_i: rsp_rdata = 0xCCCC_DDDD.
- Four back-to-back reads to 0x0, 0x4, 0x8, 0xC:
  - NONSEQ on four consecutive cycles.
  - Four rsp_valid pulses on consecutive cycles, in order.
- Read with 3 wait states:
  - haddr_o of the pipelined next request holds for 3 cycles.
  - rsp_valid arrives 3 cycles later than zero-wait.
- Write to 0x10 errors, with write to 0x14 pending:
  - rsp_err = 1 for the write to 0x10.
  - htrans_o = IDLE in the second error cycle.
  - 0x14 is re-issued afterwards and completes with rsp_err = 0.
- Reset asserted while a read is in its wait state: no rsp_valid; htrans_o = IDLE and req_ready = 1 after reset.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings and the client request record used by initiator-side logic.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam int unsigned AHB_REQ_ADDR_WIDTH = 32;
  localparam int unsigned AHB_REQ_DATA_WIDTH = 32;

  typedef struct packed {
    logic                          write;
    logic [AHB_REQ_ADDR_WIDTH-1:0] addr;
    logic [AHB_REQ_DATA_WIDTH-1:0] wdata;
  } ahb_mstr_req_t;

endpackage

// File: rtl/ahb_mstr_sif.sv
// AHB-lite initiator: turns a valid/ready client request into a single NONSEQ word transfer
// and returns a one-cycle response pulse. Address (A) and data (D) phases are pipelined.
module ahb_mstr_sif
  import ahb_lite_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH    = 32,
  parameter int unsigned AHB_DATA_WIDTH    = 64,
  parameter int unsigned CLIENT_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  // client side
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [AHB_ADDR_WIDTH-1:0]    req_addr,
  input  logic [CLIENT_DATA_WIDTH-1:0] req_wdata,
  output logic                         rsp_valid,
  output logic [CLIENT_DATA_WIDTH-1:0] rsp_rdata,
  output logic                         rsp_err,
  // AHB-lite side
  output logic [AHB_ADDR_WIDTH-1:0]    haddr_o,
  output logic [1:0]                   htrans_o,
  output logic                         hwrite_o,
  output logic [2:0]                   hsize_o,
  output logic [2:0]                   hburst_o,
  output logic [AHB_DATA_WIDTH-1:0]    hwdata_o,
  input  logic                         hready_i,
  input  logic                         hresp_i,
  input  logic [AHB_DATA_WIDTH-1:0]    hrdata_i
);

  // Word transfers only: the two byte-offset bits are always driven as zero.
  localparam logic [AHB_ADDR_WIDTH-1:0] ADDR_MASK = ~AHB_ADDR_WIDTH'(3);

  // Address-phase stage
  logic                         a_vld;
  logic [AHB_ADDR_WIDTH-1:0]    a_addr;
  logic                         a_write;
  logic [CLIENT_DATA_WIDTH-1:0] a_wdata;

  // Data-phase stage
  logic                         d_vld;
  logic                         d_addr2;
  logic                         d_write;
  logic [CLIENT_DATA_WIDTH-1:0] d_wdata;

  // High in the second error cycle; suppresses the pending A transfer for that cycle.
  logic                         kill_q;

  logic                         cancel;
  logic                         addr_accept;
  logic                         req_fire;
  logic                         d_done;
  logic [CLIENT_DATA_WIDTH-1:0] lane_rdata;

  assign cancel      = d_vld & hresp_i & ~hready_i;
  // The forced-IDLE cycle must not count as an accepted address phase, otherwise the
  // pending transfer would be silently lost instead of re-issued.
  assign addr_accept = a_vld & hready_i & ~cancel & ~kill_q;
  assign req_ready   = ~a_vld | addr_accept;
  assign req_fire    = req_valid & req_ready;
  assign d_done      = d_vld & hready_i;

  assign htrans_o = (a_vld & ~kill_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o  = a_addr;
  assign hwrite_o = a_write;
  assign hsize_o  = HSIZE_WORD;
  assign hburst_o = HBURST_SINGLE;

  // Lane steering for write data replication and read data selection.
  if (AHB_DATA_WIDTH == 2 * CLIENT_DATA_WIDTH) begin : g_bus64
    assign hwdata_o   = {d_wdata, d_wdata};
    assign lane_rdata = d_addr2 ? hrdata_i[2*CLIENT_DATA_WIDTH-1:CLIENT_DATA_WIDTH]
                                : hrdata_i[CLIENT_DATA_WIDTH-1:0];
  end else begin : g_bus32
    assign hwdata_o   = d_wdata;
    assign lane_rdata = hrdata_i[CLIENT_DATA_WIDTH-1:0];
  end

  // A stage: load a new request, or drain once the slave has taken the address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_vld   <= 1'b0;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_wdata <= '0;
    end else if (req_fire) begin
      a_vld   <= 1'b1;
      a_addr  <= req_addr & ADDR_MASK;
      a_write <= req_write;
      a_wdata <= req_wdata;
    end else if (addr_accept) begin
      a_vld   <= 1'b0;
    end
  end

  // D stage: take over from A on address acceptance, retire on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_vld   <= 1'b0;
      d_addr2 <= 1'b0;
      d_write <= 1'b0;
      d_wdata <= '0;
    end else if (addr_accept) begin
      d_vld   <= 1'b1;
      d_addr2 <= a_addr[2];
      d_write <= a_write;
      d_wdata <= a_wdata;
    end else if (d_done) begin
      d_vld   <= 1'b0;
    end
  end

  // Error tracking: the cycle after a cancel is forced IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kill_q <= 1'b0;
    end else begin
      kill_q <= cancel;
    end
  end

  // Response register: one pulse per completed data phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= d_done;
      rsp_err   <= d_done & hresp_i;
      rsp_rdata <= (d_done & ~d_write & ~hresp_i) ? lane_rdata : '0;
    end
  end

endmodule
